// File: rtl/stream_select_arbiter.sv
// Round-robin packet select generator with bounded burst reuse for the stream data mux.
// One token per packet; the token is held until the mux's last-beat handshake accepts it.
module stream_select_arbiter #(
  parameter int unsigned NUM_STREAMS = 4,
  parameter int unsigned MAX_BURST   = 1,
  parameter int unsigned COUNT_W     = 32,
  localparam int unsigned SEL_W      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_STREAMS-1:0] req_valid,
  output logic                   select_valid,
  output logic [SEL_W-1:0]       select_data,
  input  logic                   select_ready,
  output logic                   busy,
  output logic [COUNT_W-1:0]     pkt_count
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_d;
  logic [SEL_W-1:0]   last_grant, last_grant_d;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_d;
  logic [COUNT_W-1:0] pkt_count_d;

  logic               rr_hit;
  logic [SEL_W-1:0]   rr_grant;
  int unsigned        idx;
  logic [SEL_W-1:0]   idx_s;
  logic               reuse;
  logic [NUM_STREAMS-1:0] own_mask;
  logic               others_req;
  logic [BURST_W-1:0] burst_inc;
  logic [SEL_W-1:0]   sel_next;

  // Search starts at rr_ptr; wrap is taken at NUM_STREAMS, not at 2^SEL_W.
  always_comb begin
    rr_hit   = 1'b0;
    rr_grant = '0;
    idx      = 0;
    idx_s    = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
      idx_s = idx[SEL_W-1:0];
      if (!rr_hit && req_valid[idx_s]) begin
        rr_hit   = 1'b1;
        rr_grant = idx_s;
      end
    end
  end

  assign reuse = req_valid[last_grant] && (burst_cnt != '0) &&
                 (burst_cnt < BURST_W'(MAX_BURST));

  assign own_mask   = NUM_STREAMS'(1) << sel_q;
  assign others_req = |(req_valid & ~own_mask);
  assign burst_inc  = burst_cnt + BURST_W'(1);
  assign sel_next   = (sel_q == SEL_W'(NUM_STREAMS - 1)) ? '0 : sel_q + SEL_W'(1);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr;
    last_grant_d = last_grant;
    burst_cnt_d  = burst_cnt;
    pkt_count_d  = pkt_count;
    unique case (state_q)
      IDLE: begin
        if (enable && (|req_valid)) begin
          state_d     = GRANT;
          sel_d       = reuse ? last_grant : rr_grant;
          burst_cnt_d = reuse ? burst_cnt : '0;
        end
      end
      GRANT: begin
        if (select_ready) begin
          state_d      = IDLE;
          pkt_count_d  = pkt_count + COUNT_W'(1);
          last_grant_d = sel_q;
          if ((burst_inc == BURST_W'(MAX_BURST)) || !others_req) begin
            rr_ptr_d    = sel_next;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr     <= '0;
      last_grant <= '0;
      burst_cnt  <= '0;
      pkt_count  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr     <= rr_ptr_d;
      last_grant <= last_grant_d;
      burst_cnt  <= burst_cnt_d;
      pkt_count  <= pkt_count_d;
    end
  end

  assign select_valid = (state_q == GRANT);
  assign select_data  = sel_q;
  assign busy         = select_valid;

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Directed bench: three arbiter instances (4x1 round-robin, 4x3 burst, 3x1 wrap).
module tb_stream_select_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  rq_a, rq_b;
  logic [2:0]  rq_c;
  logic        rdy  [3];
  logic        sv   [3];
  logic [1:0]  sd   [3];
  logic        bz   [3];
  logic [31:0] pc   [3];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(1), .COUNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(rq_a),
    .select_valid(sv[0]), .select_data(sd[0]), .select_ready(rdy[0]),
    .busy(bz[0]), .pkt_count(pc[0]));

  stream_select_arbiter #(.NUM_STREAMS(4), .MAX_BURST(3), .COUNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(rq_b),
    .select_valid(sv[1]), .select_data(sd[1]), .select_ready(rdy[1]),
    .busy(bz[1]), .pkt_count(pc[1]));

  stream_select_arbiter #(.NUM_STREAMS(3), .MAX_BURST(1), .COUNT_W(32)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(rq_c),
    .select_valid(sv[2]), .select_data(sd[2]), .select_ready(rdy[2]),
    .busy(bz[2]), .pkt_count(pc[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (bounded) for a token, checks index and latency, optionally accepts it.
  task automatic grant(input int k, input logic [1:0] exp, input int exp_lat,
                       input bit accept, input string tag);
    int lat = 0;
    while (!sv[k] && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_valid"}, 32'(sv[k]), 32'd1);
    check({tag, "_sel"}, 32'(sd[k]), 32'(exp));
    check({tag, "_busy"}, 32'(bz[k]), 32'd1);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (accept) begin
      rdy[k] = 1'b1;
      tick();
      rdy[k] = 1'b0;
      check({tag, "_gap"}, 32'(sv[k]), 32'd0);
    end
  endtask

  logic [1:0] burst_seq [7];

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    rq_a   = 4'b1111;
    rq_b   = '0;
    rq_c   = '0;
    for (int i = 0; i < 3; i++) rdy[i] = 1'b0;
    burst_seq = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};

    tick(); tick();
    check("rst_valid", 32'(sv[0]), 32'd0);
    check("rst_sel", 32'(sd[0]), 32'd0);
    check("rst_count", pc[0], 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle_valid%0d", i), 32'(sv[0]), 32'd0);
      check($sformatf("idle_count%0d", i), pc[0], 32'd0);
    end

    // Plain round-robin across four requesters
    enable = 1'b1;
    for (int i = 0; i < 8; i++)
      grant(0, 2'(i % 4), 1, 1'b1, $sformatf("rr%0d", i));
    rq_a = '0;
    check("rr_count", pc[0], 32'd8);

    // Burst of three per stream, alternating between 0 and 2
    rq_b = 4'b0101;
    for (int i = 0; i < 7; i++)
      grant(1, burst_seq[i], 1, 1'b1, $sformatf("burst%0d", i));
    rq_b = '0;
    check("burst_count", pc[1], 32'd7);

    // Sticky grant: the requester withdraws but the token stays put
    rq_a = 4'b0010;
    grant(0, 2'd1, 1, 1'b0, "sticky");
    rq_a = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("sticky_v%0d", i), 32'(sv[0]), 32'd1);
      check($sformatf("sticky_d%0d", i), 32'(sd[0]), 32'd1);
    end
    rdy[0] = 1'b1;
    tick();
    check("sticky_acc_valid", 32'(sv[0]), 32'd0);
    check("sticky_acc_count", pc[0], 32'd9);
    // Ready without a token must not count
    tick(); tick();
    rdy[0] = 1'b0;
    check("ready_idle_count", pc[0], 32'd9);
    check("ready_idle_valid", 32'(sv[0]), 32'd0);

    // Three streams: reach rr_ptr=2, then wrap and skip
    rq_c = 3'b010;
    grant(2, 2'd1, 1, 1'b1, "wrap_setup");
    rq_c = 3'b011;
    grant(2, 2'd0, 1, 1'b1, "wrap_first");
    grant(2, 2'd1, 1, 1'b1, "wrap_second");
    rq_c = 3'b100;
    grant(2, 2'd2, 1, 1'b1, "wrap_top");
    rq_c = 3'b111;
    grant(2, 2'd0, 1, 1'b1, "wrap_zero");
    rq_c = '0;
    check("wrap_count", pc[2], 32'd5);

    // Async reset while a token is outstanding
    rq_a = 4'b1111;
    grant(0, 2'd2, 1, 1'b0, "pre_reset");
    #3 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(sv[0]), 32'd0);
    check("areset_busy", 32'(bz[0]), 32'd0);
    check("areset_count", pc[0], 32'd0);
    tick();
    rst_n = 1'b1;
    grant(0, 2'd0, 1, 1'b1, "post_reset");
    grant(0, 2'd1, 1, 1'b1, "post_reset2");
    rq_a = '0;
    check("post_reset_count", pc[0], 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_select_arbiter.md
Name: stream_select_arbiter

Overview:
- Generates the packet-level select stream for the stream data multiplexer, which sits directly downstream.
- Watches the valid lines of the NUM_STREAMS input streams and grants one stream at a time using round-robin.
- Can keep granting the same stream for up to MAX_BURST consecutive packets before rotating.
- Each grant is issued as a select token and held until the multiplexer accepts it. Acceptance happens on the last-beat handshake of that stream's packet.

Parameters:
- NUM_STREAMS, 4, number of input streams arbitrated; minimum 1.
- MAX_BURST, 1, maximum consecutive packets granted to one stream while others are requesting; minimum 1.
- COUNT_W, 32, width of the granted-packet counter.
- SEL_W, derived: $clog2(NUM_STREAMS), forced to 1 when NUM_STREAMS is 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grant is issued; a grant already issued is held.
- req_valid  input  NUM_STREAMS  valid bit of each input stream (observed only, never consumed).
- select_valid  output  1  select token valid.
- select_data  output  SEL_W  index of the granted stream.
- select_ready  input  1  token accepted (multiplexer's last-beat handshake).
- busy  output  1  high while a grant is outstanding (equal to select_valid).
- pkt_count  output  COUNT_W  total tokens accepted since reset; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, select_valid=0, select_data=0, busy=0, pkt_count=0.
  - rr_ptr=0, burst_cnt=0, last_grant=0.
- State machine with two states: IDLE and GRANT.
- IDLE:
  - If enable=1 and req_valid is not zero, compute a grant g, latch select_data=g and go to GRANT.
  - select_valid rises the cycle after req_valid is sampled, so there is 1 cycle of latency.
  - Otherwise stay in IDLE with select_valid=0.
- Grant selection in IDLE:
  - Burst reuse: if req_valid[last_grant]=1 and 0 < burst_cnt < MAX_BURST, then g=last_grant.
  - Otherwise g is the first set bit of req_valid searching rr_ptr, rr_ptr+1, …, wrapping past NUM_STREAMS-1 to 0.
  - Once a grant is computed, burst_cnt continues only when the grant equals last_grant and comes from burst reuse. In every other case burst_cnt restarts at 0.
- GRANT:
  - select_valid=1; select_data is held stable even if req_valid[g] drops (sticky grant, no retraction).
  - enable is ignored while in GRANT.
- Acceptance (select_valid & select_ready):
  - pkt_count increments by 1 (wraps).
  - last_grant=g and burst_cnt=burst_cnt+1.
  - If burst_cnt+1 equals MAX_BURST, or no other stream is requesting, rr_ptr moves to (g+1) mod NUM_STREAMS and burst_cnt returns to 0. Otherwise rr_ptr is unchanged.
  - Next state is IDLE, so back-to-back tokens are separated by exactly one cycle with select_valid=0.
- Single requester: with only one stream requesting, that stream is granted repeatedly. No starvation is possible because there are no other requesters.
- NUM_STREAMS=1: select_data is always 0.
- select_ready while select_valid=0 is ignored; no state change.
- Reset mid-grant: select_valid drops asynchronously, all state returns to reset values, and the in-flight token is discarded.
- Stream index arithmetic uses SEL_W-bit modular wrap at NUM_STREAMS. Non-power-of-two NUM_STREAMS wraps to 0 explicitly, not at 2^SEL_W.

Test Plan:
- Reset and idle: hold rst_n=0 with req_valid=4'b1111, then release with enable=0 for 5 cycles -> select_valid=0 and pkt_count=0 throughout.
- Round-robin: NUM_STREAMS=4, MAX_BURST=1, req_valid=4'b1111, select_ready pulsed whenever select_valid is high -> select_data sequence 0,1,2,3,0,…, each token separated by one idle cycle, pkt_count=8 after 8 acceptances.
- Burst: MAX_BURST=3, req_valid=4'b0101 held -> select_data sequence 0,0,0,2,2,2,0.
- Sticky grant: grant stream 1, then drop req_valid[1] while select_ready=0 for 10 cycles -> select_valid stays 1 and select_data stays 1 until select_ready.
- Wrap and skip: NUM_STREAMS=3, rr_ptr=2 reached, req_valid=3'b011 -> next grant is 0 (wrap), then 1.
- Async reset mid-grant: assert rst_n=0 between clock edges while select_valid=1 -> select_valid=0 before the next edge; after release, the first grant starts from stream 0.
